// File: rtl/alu_pkg.sv
// Shared opcode and function encodings, instruction field positions and sequencer state type
// for the ALU sequencer.
package alu_pkg;

  localparam int unsigned InstrW = 12;
  localparam int unsigned OpcMsb = 11;
  localparam int unsigned OpcLsb = 6;
  localparam int unsigned RdMsb  = 5;
  localparam int unsigned RdLsb  = 3;
  localparam int unsigned RsMsb  = 2;
  localparam int unsigned RsLsb  = 0;

  localparam logic [2:0] OpAdd   = 3'b010;
  localparam logic [2:0] OpMatch = 3'b011;
  localparam logic [2:0] OpLt    = 3'b100;
  localparam logic [2:0] OpDist  = 3'b101;
  localparam logic [2:0] OpAType = 3'b110;
  localparam logic [2:0] OpBType = 3'b111;

  localparam logic [2:0] FuncLsl  = 3'b000;
  localparam logic [2:0] FuncLsr  = 3'b001;
  localparam logic [2:0] FuncIncr = 3'b010;
  localparam logic [2:0] FuncAnd1 = 3'b011;
  localparam logic [2:0] FuncEqz  = 3'b100;
  localparam logic [2:0] FuncZero = 3'b101;
  localparam logic [2:0] FuncHalt = 3'b111;

  localparam logic [2:0] FuncBno = 3'b000;
  localparam logic [2:0] FuncBof = 3'b001;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWait,
    StWb,
    StBranch,
    StHalt
  } alu_seq_state_t;

endpackage

// File: rtl/alu_seq_decode.sv
// Combinational opcode classifier: write-back, flag-update, branch, halt and illegal.
module alu_seq_decode
  import alu_pkg::*;
(
  input  logic [5:0] opcode,
  output logic       writes_rd,
  output logic       sets_flag,
  output logic       is_branch,
  output logic       is_halt,
  output logic       is_illegal
);

  logic [2:0] op;
  logic [2:0] func;

  assign op   = opcode[5:3];
  assign func = opcode[2:0];

  always_comb begin
    writes_rd  = 1'b0;
    sets_flag  = 1'b0;
    is_branch  = 1'b0;
    is_halt    = 1'b0;
    is_illegal = 1'b0;
    unique case (op)
      OpAdd: begin
        writes_rd = 1'b1;
        sets_flag = 1'b1;
      end
      OpMatch: sets_flag = 1'b1;
      OpLt:    sets_flag = 1'b1;
      OpDist:  writes_rd = 1'b1;
      OpAType: begin
        unique case (func)
          FuncLsl: begin
            writes_rd = 1'b1;
            sets_flag = 1'b1;
          end
          FuncLsr:  writes_rd  = 1'b1;
          FuncIncr: writes_rd  = 1'b1;
          FuncAnd1: sets_flag  = 1'b1;
          FuncEqz:  sets_flag  = 1'b1;
          FuncZero: writes_rd  = 1'b1;
          FuncHalt: is_halt    = 1'b1;
          default:  is_illegal = 1'b1;
        endcase
      end
      OpBType: begin
        if (func == FuncBno || func == FuncBof) begin
          is_branch = 1'b1;
        end else begin
          is_illegal = 1'b1;
        end
      end
      default: is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle sequencer for the shared registered ALU: issue, wait, write-back, branch, halt.
// Define ALU_SEQ_ILLEGAL_TRAP_EN to make an illegal opcode halt instead of acting as a NOP.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned ALU_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [InstrW-1:0] instr,
  output logic [2:0]        rf_raddr1,
  output logic [2:0]        rf_raddr2,
  input  logic [7:0]        rf_rdata1,
  input  logic [7:0]        rf_rdata2,
  output logic              rf_we,
  output logic [2:0]        rf_waddr,
  output logic [7:0]        rf_wdata,
  output logic [7:0]        alu_in1,
  output logic [7:0]        alu_in2,
  output logic [5:0]        alu_opcode,
  input  logic [7:0]        alu_result,
  input  logic              alu_overflow,
  output logic              ov_flag,
  output logic              branch_taken,
  output logic              halted,
  output logic              illegal
);

  localparam int unsigned CntW = (ALU_LAT > 2) ? $clog2(ALU_LAT - 1) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(ALU_LAT - 2);

  alu_seq_state_t    state_q, state_d;
  logic [InstrW-1:0] instr_q, instr_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              ov_q, ov_d;
  logic              illegal_q, illegal_d;
  logic [7:0]        in1_q, in1_d, in2_q, in2_d;

  logic       in_idle;
  logic [5:0] dec_opcode;
  logic       writes_rd, sets_flag, is_branch, is_halt, is_illegal;

  assign in_idle = (state_q == StIdle);

  // Decode the live instruction while idle so the accept edge can pick the next state.
  assign dec_opcode = in_idle ? instr[OpcMsb:OpcLsb] : instr_q[OpcMsb:OpcLsb];

  alu_seq_decode u_decode (
    .opcode     (dec_opcode),
    .writes_rd  (writes_rd),
    .sets_flag  (sets_flag),
    .is_branch  (is_branch),
    .is_halt    (is_halt),
    .is_illegal (is_illegal)
  );

  always_comb begin
    state_d      = state_q;
    instr_d      = instr_q;
    cnt_d        = cnt_q;
    ov_d         = ov_q;
    illegal_d    = 1'b0;
    in1_d        = in1_q;
    in2_d        = in2_q;
    rf_we        = 1'b0;
    branch_taken = 1'b0;
    alu_in1      = in1_q;
    alu_in2      = in2_q;
    unique case (state_q)
      StIdle: begin
        if (instr_valid) begin
          instr_d = instr;
          if (is_illegal) begin
            illegal_d = 1'b1;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
            state_d = StHalt;
`else
            state_d = StIdle;
`endif
          end else if (is_branch) begin
            state_d = StBranch;
          end else if (is_halt) begin
            state_d = StHalt;
          end else begin
            state_d = StIssue;
          end
        end
      end
      StIssue: begin
        alu_in1 = rf_rdata1;
        alu_in2 = rf_rdata2;
        in1_d   = rf_rdata1;
        in2_d   = rf_rdata2;
        if (ALU_LAT > 1) begin
          cnt_d   = CntLoad;
          state_d = StWait;
        end else begin
          state_d = StWb;
        end
      end
      StWait: begin
        if (cnt_q == '0) begin
          state_d = StWb;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StWb: begin
        rf_we = writes_rd;
        if (sets_flag) begin
          ov_d = alu_overflow;
        end
        state_d = StIdle;
      end
      StBranch: begin
        branch_taken = (instr_q[OpcLsb+2:OpcLsb] == FuncBof) ? ov_q : ~ov_q;
        state_d      = StIdle;
      end
      StHalt: state_d = StHalt;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      instr_q   <= '0;
      cnt_q     <= '0;
      ov_q      <= 1'b0;
      illegal_q <= 1'b0;
      in1_q     <= '0;
      in2_q     <= '0;
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      cnt_q     <= cnt_d;
      ov_q      <= ov_d;
      illegal_q <= illegal_d;
      in1_q     <= in1_d;
      in2_q     <= in2_d;
    end
  end

  assign halted      = (state_q == StHalt);
  assign instr_ready = in_idle & ~halted;
  assign rf_raddr1   = in_idle ? instr[RdMsb:RdLsb] : instr_q[RdMsb:RdLsb];
  assign rf_raddr2   = in_idle ? instr[RsMsb:RsLsb] : instr_q[RsMsb:RsLsb];
  assign rf_waddr    = instr_q[RdMsb:RdLsb];
  assign rf_wdata    = alu_result;
  assign alu_opcode  = instr_q[OpcMsb:OpcLsb];
  assign ov_flag     = ov_q;
  assign illegal     = illegal_q;

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Multi-cycle control unit that accepts one instruction at a time from the fetch stage and sequences the shared 8-bit registered ALU. For each instruction it reads register-file operands, issues opcode and operands to the ALU, and waits the ALU's fixed latency. It then writes back the result, updates the sticky overflow/condition flag, and resolves BNO/BOF branches and HALT. It sits between the fetch unit, the register file and the ALU.

## Interface
- ALU_LAT, 1: ALU result latency in cycles after issue, ≥1.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high.
- instr_valid  in  1  fetch presents an instruction.
- instr_ready  out  1  sequencer can accept; high only in IDLE.
- instr  in  12  {opcode[11:6] = {op[5:3], func[2:0]}, rd[5:3], rs[2:0]}.
- rf_raddr1 / rf_raddr2  out  3 each  rd / rs; register file reads asynchronously.
- rf_rdata1 / rf_rdata2  in  8 each  operand data.
- rf_we  out  1  write strobe.
- rf_waddr  out  3  write address (rd).
- rf_wdata  out  8  write data.
- alu_in1, alu_in2  out  8 each  ALU operands.
- alu_opcode  out  6  ALU opcode.
- alu_result  in  8  ALU result.
- alu_overflow  in  1  ALU flag output.
- ov_flag  out  1  architectural condition flag.
- branch_taken  out  1  one-cycle pulse to fetch.
- halted  out  1  sticky halt indicator.
- illegal  out  1  one-cycle pulse on an undefined opcode.

## Operation
- Opcode groups:
  - ADD = 010, MATCH = 011, LT = 100, DIST = 101.
  - A-type 110, funcs: LSL 000, LSR 001, INCR 010, AND1 011, EQZ 100, ZERO 101, reserved 110, HALT 111.
  - B-type 111, funcs: BNO 000, BOF 001, 010–111 reserved.
- Write-back set: ADD, DIST, LSL, LSR, INCR, ZERO.
- Flag-update set: ADD, MATCH, LT, LSL, AND1, EQZ.
- Illegal: op 000/001, A-func 110, B-func 010–111.
- States: IDLE, ISSUE, WAIT, WB, BRANCH, HALT.
- IDLE: on instr_valid & instr_ready, latch instr.
  - ALU op → ISSUE.
  - BNO/BOF → BRANCH.
  - HALT func → HALT.
  - Illegal → pulse illegal, return to IDLE (NOP).
- ISSUE: drive alu_in1 = rf_rdata1, alu_in2 = rf_rdata2, alu_opcode = latched opcode.
  - → WAIT if ALU_LAT > 1, else → WB.
- WAIT: down-counter loaded with ALU_LAT−2; → WB when it reaches 0.
  - alu_opcode and operands held at the ISSUE values.
- WB: rf_we = 1 for write-back ops, with rf_waddr = rd and rf_wdata = alu_result.
  - ov_flag <= alu_overflow for flag ops; other ops leave ov_flag unchanged. → IDLE.
- BRANCH: branch_taken = (BNO ? ~ov_flag : ov_flag). → IDLE. ov_flag unchanged.
- HALT: halted = 1, instr_ready = 0. Exit only by reset.
- rf_raddr1/2 come from the latched instr in ISSUE through WB and from the live instr in IDLE.

## Timing
- Reset values: state IDLE, ov_flag 0, halted 0, rf_we 0, branch_taken 0, illegal 0, alu_opcode 0, alu_in1/2 0, WAIT counter 0.
- instr_ready = (state == IDLE) & ~halted. It may read 1 during reset, but nothing is accepted while reset is high.
- Accept edge at cycle T (ALU op):
  - ISSUE in T+1; WB in T+1+ALU_LAT.
  - ov_flag visible in T+2+ALU_LAT; instr_ready high again in T+2+ALU_LAT.
- Branch: branch_taken high in T+1, ready in T+2.
- Illegal: illegal pulses in T+1 (combinational on the accept cycle registered), ready in T+1.
- instr must be stable while instr_valid & ~instr_ready. instr_valid outside IDLE is ignored.
- Back-to-back flag producer followed by a branch: the branch sees the updated flag, because BRANCH starts after WB.
- Reset mid-instruction: immediate return to IDLE. No rf_we pulse and no flag update for the aborted instruction.
- rf_we, branch_taken and illegal are each high for exactly one cycle per instruction.

## Configuration
- Macro ALU_SEQ_ILLEGAL_TRAP_EN.
- Defined: an illegal opcode moves to HALT. illegal pulses and halted sets in T+1.
- Undefined: an illegal opcode is a NOP (illegal pulse only, back to IDLE).

## Structure
- Shared package alu_pkg:
  - op and func localparams.
  - state enum (alu_seq_state_t).
  - instruction field slicing constants.
- One combinational sub-module, alu_seq_decode. Opcode in; outputs writes_rd, sets_flag, is_branch, is_halt, is_illegal.
- FSM, latch and counter live in alu_sequencer.

## Test plan
- ADD r1 = 0xF0, r2 = 0x20 (ALU_LAT = 1), accept at T → rf_we in T+2, waddr 1, wdata 0x10; ov_flag = 1 in T+3.
- MATCH on 0x5A/0x5A, then BNO → no write, ov_flag = 1, branch_taken stays 0. Follow with BOF → branch_taken = 1 for one cycle.
- ALU_LAT = 3, INCR r4 = 0xFF → alu_opcode held for 3 cycles, wdata 0x00 in T+4, ov_flag unchanged.
- HALT func (110_111) → halted = 1 and instr_ready = 0 forever, instr_valid ignored. Reset → halted = 0, ov_flag = 0.
- Opcode 000_000 → illegal pulse. Without macro: next instruction accepted in T+1. With macro: halted = 1.
- Reset asserted in the ISSUE cycle of LSL → no rf_we, ov_flag = 0, state IDLE after release.
